alu_mul_seq: RTL and testbench

//  Multi-cycle unsigned multiplier sequencer driving the 16-bit ALU (ex/nx/ey/ny/f/no control).

---
 rtl/alu_ctl_pkg.sv | 16 +
 rtl/alu_mul_seq_if.sv | 22 ++
 rtl/alu_mul_seq.sv | 139 +++++++++++++
 tb/tb_alu_mul_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctl_pkg.sv
// Shared ALU control encodings and sequencer state type for ALU-driving helpers.
// Control word layout is {ex, nx, ey, ny, f, no}.
package alu_ctl_pkg;

    localparam logic [5:0] ALU_ADD   = 6'b101010;
    localparam logic [5:0] ALU_ZERO  = 6'b000010;
    localparam logic [5:0] ALU_PASSX = 6'b100100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DBL  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result handshake between the microsequencer and the multiply sequencer.
interface alu_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU for every addition,
// producing the low WIDTH bits of A*B plus an exact unsigned overflow flag.
module alu_mul_seq
    import alu_ctl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    alu_mul_seq_if.slave      bus,
    output logic [WIDTH-1:0]  alu_x,
    output logic [WIDTH-1:0]  alu_y,
    output logic [5:0]        alu_c,
    output logic              alu_cin,
    output logic              alu_en,
    input  logic [WIDTH-1:0]  alu_val,
    input  logic              alu_cflag
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_t       state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mc_r;
    logic [WIDTH-1:0] mb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             ovf_r;

    logic [WIDTH-1:0] mb_shift_s;
    logic             mb_live_s;

    // Multiplier bits still to process once the current bit is consumed.
    always_comb begin
        mb_shift_s = mb_r >> 1;
        mb_live_s  = |mb_shift_s;
    end

    // Sequencer FSM with accumulator/multiplicand/multiplier registers and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            acc_r    <= '0;
            mc_r     <= '0;
            mb_r     <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_r <= '0;
                        mc_r  <= bus.op_a;
                        mb_r  <= bus.op_b;
                        cnt_r <= '0;
                        ovf_r <= 1'b0;
                        if (bus.op_b == '0) begin
                            // Nothing to add: the product is zero and result is published directly.
                            state_r  <= ST_DONE;
                            done_r   <= 1'b1;
                            result_r <= '0;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= bus.op_b[0] ? ST_ADD : ST_DBL;
                        end
                    end
                end
                ST_ADD: begin
                    acc_r   <= alu_val;
                    ovf_r   <= ovf_r | alu_cflag;
                    state_r <= ST_DBL;
                end
                ST_DBL: begin
                    mc_r  <= alu_val;
                    mb_r  <= mb_shift_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    // A lost multiplicand bit only matters if a later multiplier bit would add it.
                    if (mb_live_s && alu_cflag) begin
                        ovf_r <= 1'b1;
                    end
                    if (!mb_live_s || (cnt_r == CNT_LAST)) begin
                        state_r  <= ST_DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= acc_r;
                    end else begin
                        state_r <= mb_r[1] ? ST_ADD : ST_DBL;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // ALU pin decode from the current state and internal registers only.
    always_comb begin
        alu_x = '0;
        alu_y = '0;
        alu_c = ALU_ZERO;
        case (state_r)
            ST_ADD: begin
                alu_x = acc_r;
                alu_y = mc_r;
                alu_c = ALU_ADD;
            end
            ST_DBL: begin
                alu_x = mc_r;
                alu_y = mc_r;
                alu_c = ALU_ADD;
            end
            default: begin
                alu_x = '0;
                alu_y = '0;
                alu_c = ALU_ZERO;
            end
        endcase
    end

    assign alu_cin    = 1'b0;
    assign alu_en     = 1'b0;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.ovf    = ovf_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: ALU model on the pins, arithmetic reference model,
// per-cycle compare process, directed boundary cases and a random sweep.
module tb_alu_mul_seq;

    logic        clk;
    logic        reset;
    logic [15:0] alu_x, alu_y, alu_val;
    logic [5:0]  alu_c;
    logic        alu_cin, alu_en, alu_cflag;

    alu_mul_seq_if #(.WIDTH(16)) bus ();

    alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_c     (alu_c),
        .alu_cin   (alu_cin),
        .alu_en    (alu_en),
        .alu_val   (alu_val),
        .alu_cflag (alu_cflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU with {ex,nx,ey,ny,f,no}: ex/ey gate the operand in, nx/ny invert, f selects add/and.
    always_comb begin
        logic [15:0] xv, yv, ov;
        logic [16:0] sum;
        xv = alu_c[5] ? alu_x : 16'h0000;
        if (alu_c[4]) xv = ~xv;
        yv = alu_c[3] ? alu_y : 16'h0000;
        if (alu_c[2]) yv = ~yv;
        sum = {1'b0, xv} + {1'b0, yv} + {16'h0000, alu_cin};
        if (alu_c[1]) begin
            ov = sum[15:0];
            alu_cflag = sum[16];
        end else begin
            ov = xv & yv;
            alu_cflag = 1'b0;
        end
        alu_val = alu_c[0] ? ~ov : ov;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edges from acceptance until done is visible: popcount(B) + msb index + 1, zero for B==0.
    function automatic int model_k(input logic [15:0] b);
        int msb;
        msb = -1;
        for (int i = 0; i < 16; i++) if (b[i]) msb = i;
        if (b == 16'h0000) return 0;
        return $countones(b) + msb + 1;
    endfunction

    // Reference model state, advanced on every rising edge.
    int          cyc = 0;
    bit          m_valid = 1'b0;
    bit          m_inflight = 1'b0;
    int          m_done_edge = 0;
    int          m_next_accept = 0;
    logic [15:0] m_res = 16'h0000, m_pend_res = 16'h0000;
    bit          m_ovf = 1'b0, m_pend_ovf = 1'b0;

    always @(posedge clk) begin
        logic [31:0] prod;
        cyc = cyc + 1;
        if (reset) begin
            m_valid       = 1'b1;
            m_inflight    = 1'b0;
            m_res         = 16'h0000;
            m_ovf         = 1'b0;
            m_next_accept = cyc + 1;
        end else if (m_valid) begin
            if (bus.start && cyc >= m_next_accept) begin
                prod          = 32'(bus.op_a) * 32'(bus.op_b);
                m_pend_res    = prod[15:0];
                m_pend_ovf    = (prod > 32'h0000FFFF);
                m_done_edge   = cyc + model_k(bus.op_b);
                m_next_accept = m_done_edge + 2;
                m_inflight    = 1'b1;
            end
            if (m_inflight && cyc == m_done_edge) begin
                m_res = m_pend_res;
                m_ovf = m_pend_ovf;
            end
            if (m_inflight && cyc > m_done_edge) m_inflight = 1'b0;
        end
    end

    // Compare process: checks handshake and ALU pins against the model every cycle.
    always @(negedge clk) begin
        bit exp_done, exp_busy;
        if (m_valid) begin
            exp_done = m_inflight && (cyc == m_done_edge);
            exp_busy = m_inflight && (cyc < m_done_edge);
            chk("done", 32'(bus.done), 32'(exp_done));
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("alu_cin", 32'(alu_cin), 32'd0);
            chk("alu_en", 32'(alu_en), 32'd0);
            if (exp_busy) begin
                chk("alu_c_busy", 32'(alu_c), 32'h2A);
            end else begin
                chk("alu_c_idle", 32'(alu_c), 32'h02);
                chk("alu_x_idle", 32'(alu_x), 32'd0);
                chk("alu_y_idle", 32'(alu_y), 32'd0);
                chk("result", 32'(bus.result), 32'(m_res));
                chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_bound", 32'(n < 200), 32'd1);
    endtask

    task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] er, input bit eo, input int ek);
        int n;
        chk({nm, "_model_k"}, 32'(model_k(b)), 32'(ek));
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(ek));
        chk({nm, "_result"}, 32'(bus.result), 32'(er));
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eo));
    endtask

    initial begin
        int n;
        int mode;
        logic [15:0] ra, rb;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = 16'h0000;
        bus.op_b  = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_alu_c", 32'(alu_c), 32'h02);
        chk("rst_alu_xy", 32'({alu_x, alu_y}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        directed("a3_b5", 16'd3, 16'd5, 16'd15, 1'b0, 5);
        directed("b_zero", 16'h1234, 16'h0000, 16'h0000, 1'b0, 0);
        directed("ffff_sq", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 32);
        directed("dbl_carry", 16'h8000, 16'd2, 16'h0000, 1'b1, 3);
        directed("msb_x1", 16'h8000, 16'd1, 16'h8000, 1'b0, 2);
        directed("a_zero", 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 32);

        // Abort: extra start while busy is ignored, reset kills the run without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'd7; bus.op_b = 16'd9;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'd1; bus.op_b = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        chk("abort_no_done", 32'(n), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        directed("a7_b9", 16'd7, 16'd9, 16'd63, 1'b0, 6);

        // Held start re-triggers only from IDLE; the model tracks each acceptance.
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'd300; bus.op_b = 16'd300;
        repeat (40) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        for (int i = 0; i < 1000; i++) begin
            mode = int'($urandom_range(0, 7));
            ra = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h0000;
            case (mode)
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                2, 3:    rb = 16'($urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            wait_idle();
            @(negedge clk);
            bus.start = 1'b1; bus.op_a = ra; bus.op_b = rb;
            @(negedge clk);
            bus.start = 1'b0;
            n = 0;
            while (bus.done !== 1'b1 && n < 100) begin
                @(negedge clk);
                bus.start = ($urandom_range(0, 3) == 0);
                bus.op_a  = 16'($urandom);
                bus.op_b  = 16'($urandom);
                n++;
            end
            bus.start = 1'b0;
            chk("sweep_done_bound", 32'(n < 100), 32'd1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
